// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared widths and writeback entry type for the writeback arbiter
package wb_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IDX_W_DEF  = 5;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// rtl/wb_arb_fifo.sv - long-unit result buffer; count, wrapping pointers and head outputs
module wb_arb_fifo #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [IDX_W-1:0]             push_idx,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         head_valid,
  output logic [IDX_W-1:0]             head_idx,
  output logic [DATA_W-1:0]            head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [IDX_W+DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;

  // Explicit wrap so non-power-of-two depths stay inside the array
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_idx, push_data};
  end

  assign {head_idx, head_data} = mem[rd_ptr];
  assign head_valid = (count != '0);
  assign full       = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - shares one register-file write port between M/WB and a long-latency unit
// Head aging is built in when WB_ARB_AGING_EN is defined.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int LU_DEPTH  = 2,
  parameter int AGE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic [IDX_W-1:0]  pipe_idx,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              lu_valid,
  input  logic [IDX_W-1:0]  lu_idx,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_idx,
  output logic [DATA_W-1:0] rf_data
);

  localparam int CNT_W = $clog2(LU_DEPTH+1);

  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              head_valid;
  logic [IDX_W-1:0]  head_idx;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              grant_lu;
  logic              age_hit;
  logic              pipe_live;
  logic              we_next;
  wb_entry_t         wr_next;

  wb_arb_fifo #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (LU_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_idx   (lu_idx),
    .push_data  (lu_data),
    .pop        (grant_lu),
    .count      (count),
    .full       (fifo_full),
    .head_valid (head_valid),
    .head_idx   (head_idx),
    .head_data  (head_data)
  );

  assign lu_ready = (count < CNT_W'(LU_DEPTH));
  assign push     = lu_valid && lu_ready;

  // Index-0 pipe writes never need the port, so they never block the buffer
  assign pipe_live  = pipe_valid && (pipe_idx != '0);
  assign grant_lu   = head_valid && (fifo_full || age_hit || !pipe_live);
  assign pipe_stall = pipe_live && grant_lu;
  assign we_next    = grant_lu ? (head_idx != '0) : pipe_live;

  assign wr_next.idx  = grant_lu ? head_idx  : pipe_idx;
  assign wr_next.data = grant_lu ? head_data : pipe_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we   <= 1'b0;
      rf_idx  <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= we_next;
      if (we_next) begin
        rf_idx  <= wr_next.idx;
        rf_data <= wr_next.data;
      end
    end
  end

`ifdef WB_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT+1);
  logic [AGE_W-1:0] age;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age <= '0;
    end else if (grant_lu) begin
      age <= '0;
    end else if (head_valid && (age < AGE_W'(AGE_LIMIT))) begin
      age <= age + AGE_W'(1);
    end
  end

  assign age_hit = (age >= AGE_W'(AGE_LIMIT));
`else
  // Never true: without aging the head waits for a full buffer or an idle pipe
  assign age_hit = (AGE_LIMIT < 0);
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register-file data width.
REQ-002 SHALL have parameter IDX_W, default 5, register index width.
REQ-003 SHALL have parameter LU_DEPTH, default 2, long-unit result buffer entries (>=2).
REQ-004 SHALL have parameter AGE_LIMIT, default 4, cycles before a waiting long-unit result forces the port.
REQ-005 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port pipe_valid  in  1  M/WB stage holds a writeback.
REQ-008 SHALL have port pipe_idx  in  IDX_W  M/WB destination index.
REQ-009 SHALL have port pipe_data  in  DATA_W  M/WB writeback value.
REQ-010 SHALL have port pipe_stall  out  1  hold M/WB register (drives its write enable low).
REQ-011 SHALL have port lu_valid  in  1  long-latency unit result offered.
REQ-012 SHALL have port lu_idx  in  IDX_W  long-unit destination index.
REQ-013 SHALL have port lu_data  in  DATA_W  long-unit result value.
REQ-014 SHALL have port lu_ready  out  1  buffer can accept a result this cycle.
REQ-015 SHALL have ports rf_we/rf_idx/rf_data  out  1/IDX_W/DATA_W  registered register-file write port.

Function
REQ-016 SHALL accept a long-unit result on lu_valid&&lu_ready into a FIFO of LU_DEPTH entries; lu_ready = count<LU_DEPTH.
REQ-017 SHALL grant the single write port each cycle to exactly one of: FIFO head, pipe, or none.
REQ-018 SHALL grant FIFO head when head present and any of: FIFO full, head age>=AGE_LIMIT (when aging compiled in), pipe_valid low, or pipe_idx==0; otherwise grant pipe.
REQ-019 SHALL assert pipe_stall (combinational) iff pipe_valid && pipe_idx!=0 && FIFO head granted.
REQ-020 SHALL consume pipe writes with pipe_idx==0 without using the port and without stalling.
REQ-021 SHALL drop FIFO entries with idx 0 on dequeue with rf_we low, still counting as a grant.
REQ-022 SHALL register the granted write: rf_we/rf_idx/rf_data valid one cycle after grant (latency 1).
REQ-023 SHALL allow enqueue and dequeue in the same cycle; count unchanged, enqueue legal when full only if dequeuing is not required (lu_ready stays count-based).
REQ-024 SHALL keep FIFO order per source; no ordering between pipe and long-unit writes is enforced.
REQ-025 SHALL increment head age each cycle head is present and not granted, saturating at AGE_LIMIT; clear on dequeue.
REQ-026 SHALL wrap FIFO read/write pointers modulo LU_DEPTH.

Reset
REQ-027 SHALL, on reset low, asynchronously clear FIFO count, pointers, age, rf_we, rf_idx, rf_data to 0; pipe_stall 0, lu_ready 1.
REQ-028 SHALL discard buffered results on reset mid-operation; no write issued for them after release.

Configuration
REQ-029 SHALL compile head aging in when WB_ARB_AGING_EN is defined (REQ-018 age term, REQ-025 counter present).
REQ-030 SHALL, without WB_ARB_AGING_EN, omit the age counter; FIFO wins only when full or pipe idle/idx 0.

Structure
REQ-031 SHALL place DATA_W, IDX_W defaults and the wb entry struct {idx, data} in package wb_arb_pkg.
REQ-032 SHALL implement the buffer as sub-module wb_arb_fifo (count, pointers, head outputs).

Verification
REQ-033 Pipe only: pipe idx 3 data 0xA5A5A5A5 -> next cycle rf_we=1 idx 3 data 0xA5A5A5A5, pipe_stall never 1.
REQ-034 LU with idle pipe: lu idx 7 data 0x12345678 -> rf write idx 7 two cycles after offer, lu_ready stays 1.
REQ-035 Full FIFO: two LU results while pipe busy every cycle -> lu_ready 0, pipe_stall 1 one cycle, head written first.
REQ-036 Aging (macro on): one LU entry, pipe busy with idx 5 -> after 4 denied cycles pipe_stall 1, LU written; macro off -> no stall.
REQ-037 Index 0: pipe idx 0 and LU idx 0 -> rf_we stays 0, no stall, FIFO drains.
REQ-038 Reset mid-operation: FIFO holding 2 entries, reset low one cycle -> rf_we 0, lu_ready 1, no later write of discarded entries.
